// File: rtl/ss_pkg.sv
// ss_pkg: shared FSM states, correlator register map and magnitude helper.
// Contents:
//   state_t          acquisition controller states
//   ADDR_*           correlator register addresses
//   MAG_W            width of correlation magnitudes
//   abs_sat()        |v| with -2^31 saturated to 32'h7FFF_FFFF
package ss_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_WR_FREQ, S_WR_S1, S_WR_S2, S_WR_PHASE,
        S_SETTLE, S_SYNC, S_WAIT, S_EVAL, S_DONE
    } state_t;
    localparam logic [3:0] ADDR_FREQ  = 4'd0;
    localparam logic [3:0] ADDR_PHASE = 4'd4;
    localparam logic [3:0] ADDR_S1    = 4'd8;
    localparam logic [3:0] ADDR_S2    = 4'd12;
    localparam int MAG_W = 32;
    function automatic logic [MAG_W-1:0] abs_sat(input logic [31:0] v);
        return (v == 32'h8000_0000) ? 32'h7FFF_FFFF : (v[31] ? (~v + 32'd1) : v);
    endfunction
endpackage

// File: rtl/ss_peak_track.sv
// ss_peak_track: magnitude of a captured correlation and running best-peak record.
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   clr_i            clear best record (new search)
//   upd_i            evaluate current sample against best record
//   corr_i           captured signed correlation
//   phase_i, idx_i   phase word and step index of the current sample
//   mag_o            |corr_i| (saturated)
//   best_*_o         best magnitude, its phase and step index
module ss_peak_track
    import ss_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             upd_i,
    input  logic [31:0]      corr_i,
    input  logic [31:0]      phase_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [MAG_W-1:0] mag_o,
    output logic [MAG_W-1:0] best_mag_o,
    output logic [31:0]      best_phase_o,
    output logic [IDX_W-1:0] best_idx_o
);
    logic [MAG_W-1:0] best_mag_q;
    logic [31:0]      best_phase_q;
    logic [IDX_W-1:0] best_idx_q;

    assign mag_o        = abs_sat(corr_i);
    assign best_mag_o   = best_mag_q;
    assign best_phase_o = best_phase_q;
    assign best_idx_o   = best_idx_q;

    // strict compare keeps the earliest step on ties
    always_ff @(posedge clk) begin
        if (!reset || clr_i) begin
            best_mag_q   <= '0;
            best_phase_q <= '0;
            best_idx_q   <= '0;
        end else if (upd_i && mag_o > best_mag_q) begin
            best_mag_q   <= mag_o;
            best_phase_q <= phase_i;
            best_idx_q   <= idx_i;
        end
    end
endmodule

// File: rtl/ss_acq_ctrl.sv
// ss_acq_ctrl: phase-search acquisition controller driving a spread-spectrum correlator.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   start, abort               search request (IDLE only), search abort
//   cfg_*                      search configuration, latched on accepted start
//   busy, done, timeout_err    status (done one-cycle, timeout_err sticky)
//   best_phase/mag/idx         strongest correlation found
//   ss_din/addr/strobe/sync    correlator register bus and sync pulse
//   ss_push_corr, ss_corr      correlator result handshake
// Build option: define ACQ_THRESH_EN to stop early once a magnitude reaches cfg_thresh.
module ss_acq_ctrl
    import ss_pkg::*;
#(
    parameter int NSTEP_W = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        cfg_freq,
    input  logic [31:0]        cfg_phase0,
    input  logic [31:0]        cfg_phase_step,
    input  logic [31:0]        cfg_thresh,
    input  logic [3:0]         cfg_s1,
    input  logic [3:0]         cfg_s2,
    input  logic [NSTEP_W-1:0] cfg_nsteps,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [31:0]        best_phase,
    output logic [31:0]        best_mag,
    output logic [NSTEP_W-1:0] best_idx,
    output logic [31:0]        ss_din,
    output logic [3:0]         ss_addr,
    output logic               ss_strobe,
    output logic               ss_sync,
    input  logic               ss_push_corr,
    input  logic [31:0]        ss_corr
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [NSTEP_W-1:0] k_q, k_d, nsteps_q, nsteps_d;
    logic [31:0]        freq_q, freq_d, phase_q, phase_d, step_q, step_d, corr_q, corr_d;
    logic [3:0]         s1_q, s1_d, s2_q, s2_d;
    logic               settle_q, settle_d, timeout_q, timeout_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               busy_q, busy_d, done_q, done_d, strobe_q, strobe_d, sync_q, sync_d;
    logic [3:0]         addr_q, addr_d;
    logic [31:0]        din_q, din_d;
    logic [MAG_W-1:0]   mag;
    logic               accept, stop;

    assign accept = (state_q == S_IDLE) && start && !abort;

`ifdef ACQ_THRESH_EN
    logic [31:0] thresh_q, thresh_d;
    assign thresh_d = accept ? cfg_thresh : thresh_q;
    assign stop     = mag >= thresh_q;
    always_ff @(posedge clk) thresh_q <= !reset ? '0 : thresh_d;
`else
    logic unused_thresh;
    assign unused_thresh = ^cfg_thresh;
    assign stop          = 1'b0;
`endif

    ss_peak_track #(.IDX_W(NSTEP_W)) u_peak (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (accept),
        .upd_i        (state_q == S_EVAL && !abort),
        .corr_i       (corr_q),
        .phase_i      (phase_q),
        .idx_i        (k_q),
        .mag_o        (mag),
        .best_mag_o   (best_mag),
        .best_phase_o (best_phase),
        .best_idx_o   (best_idx)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        nsteps_d  = nsteps_q;
        freq_d    = freq_q;
        phase_d   = phase_q;
        step_d    = step_q;
        corr_d    = corr_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        settle_d  = settle_q;
        timeout_d = timeout_q;
        tcnt_d    = tcnt_q;
        case (state_q)
            S_IDLE: if (accept) begin
                freq_d    = cfg_freq;
                phase_d   = cfg_phase0;
                step_d    = cfg_phase_step;
                s1_d      = cfg_s1;
                s2_d      = cfg_s2;
                nsteps_d  = cfg_nsteps;
                k_d       = '0;
                timeout_d = 1'b0;
                state_d   = (cfg_nsteps != '0) ? S_WR_FREQ : S_DONE;
            end
            S_WR_FREQ:  state_d = S_WR_S1;
            S_WR_S1:    state_d = S_WR_S2;
            S_WR_S2:    state_d = S_WR_PHASE;
            S_WR_PHASE: begin
                settle_d = 1'b0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                settle_d = 1'b1;
                state_d  = settle_q ? S_SYNC : S_SETTLE;
            end
            S_SYNC: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: if (ss_push_corr) begin
                corr_d  = ss_corr;
                state_d = S_EVAL;
            end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                timeout_d = 1'b1;
                state_d   = S_DONE;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
            S_EVAL: if ((k_q + 1'b1) == nsteps_q || stop) begin
                state_d = S_DONE;
            end else begin
                k_d     = k_q + 1'b1;
                phase_d = phase_q + step_q;
                state_d = S_WR_PHASE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
        // bus/status outputs are decoded from the next state so they are registered
        busy_d   = state_d != S_IDLE;
        done_d   = state_d == S_DONE;
        sync_d   = state_d == S_SYNC;
        strobe_d = state_d inside {S_WR_FREQ, S_WR_S1, S_WR_S2, S_WR_PHASE};
        addr_d   = (state_d == S_WR_FREQ)  ? ADDR_FREQ  :
                   (state_d == S_WR_S1)    ? ADDR_S1    :
                   (state_d == S_WR_S2)    ? ADDR_S2    :
                   (state_d == S_WR_PHASE) ? ADDR_PHASE : addr_q;
        din_d    = (state_d == S_WR_FREQ)  ? freq_d         :
                   (state_d == S_WR_S1)    ? {28'b0, s1_d}  :
                   (state_d == S_WR_S2)    ? {28'b0, s2_d}  :
                   (state_d == S_WR_PHASE) ? phase_d        : din_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            nsteps_q  <= '0;
            freq_q    <= '0;
            phase_q   <= '0;
            step_q    <= '0;
            corr_q    <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            settle_q  <= 1'b0;
            timeout_q <= 1'b0;
            tcnt_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            strobe_q  <= 1'b0;
            sync_q    <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            nsteps_q  <= nsteps_d;
            freq_q    <= freq_d;
            phase_q   <= phase_d;
            step_q    <= step_d;
            corr_q    <= corr_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            settle_q  <= settle_d;
            timeout_q <= timeout_d;
            tcnt_q    <= tcnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            strobe_q  <= strobe_d;
            sync_q    <= sync_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign ss_strobe   = strobe_q;
    assign ss_sync     = sync_q;
    assign ss_addr     = addr_q;
    assign ss_din      = din_q;
endmodule

// File: tb/tb_ss_acq_ctrl.sv
// tb_ss_acq_ctrl: randomized, model-checked bench for ss_acq_ctrl acting as the correlator.
module tb_ss_acq_ctrl;
    localparam int TO = 4096;

    logic        clk = 0, reset = 0, start = 0, abort = 0;
    logic [31:0] cfg_freq = 0, cfg_phase0 = 0, cfg_phase_step = 0, cfg_thresh = 0;
    logic [3:0]  cfg_s1 = 0, cfg_s2 = 0;
    logic [9:0]  cfg_nsteps = 0;
    logic        busy, done, timeout_err, ss_strobe, ss_sync;
    logic [31:0] best_phase, best_mag, ss_din, ss_corr = 0;
    logic [9:0]  best_idx;
    logic [3:0]  ss_addr;
    logic        ss_push_corr = 0;

    ss_acq_ctrl #(.NSTEP_W(10), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_freq(cfg_freq), .cfg_phase0(cfg_phase0), .cfg_phase_step(cfg_phase_step),
        .cfg_thresh(cfg_thresh), .cfg_s1(cfg_s1), .cfg_s2(cfg_s2), .cfg_nsteps(cfg_nsteps),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .best_phase(best_phase), .best_mag(best_mag), .best_idx(best_idx),
        .ss_din(ss_din), .ss_addr(ss_addr), .ss_strobe(ss_strobe), .ss_sync(ss_sync),
        .ss_push_corr(ss_push_corr), .ss_corr(ss_corr)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc++;

    // search descriptor and model expectations
    logic [31:0] c_freq, c_phase0, c_step, c_thresh;
    logic [3:0]  c_s1, c_s2;
    int          c_nsteps;
    logic [31:0] corr_a [16];
    int          dly_a [16], len_a [16];
    bit          spur_a [16], xst_a [16];
    logic [35:0] exp_wr [$];
    longint      exp_mag;
    logic [31:0] exp_phase;
    int          exp_idx;
    bit          exp_to, exp_done;

    // compare-side observations
    int          done_cnt = 0, strobe_cnt = 0, ph_cnt = 0;
    int          last_ph_cyc = -100, last_sync_cyc = -100;
    logic [31:0] last_ph_din = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint mdl_mag(input logic [31:0] c);
        longint v = longint'($signed(c));
        if (v < 0) v = -v;
        return (v > 64'h7FFF_FFFF) ? 64'h7FFF_FFFF : v;
    endfunction

    task automatic build_model(input int abort_k);
        logic [31:0] kk;
        longint m;
        exp_wr.delete();
        exp_mag = 0; exp_phase = 0; exp_idx = 0; exp_to = 0;
        if (c_nsteps != 0) begin
            exp_wr.push_back({4'd0, c_freq});
            exp_wr.push_back({4'd8, 28'b0, c_s1});
            exp_wr.push_back({4'd12, 28'b0, c_s2});
        end
        for (int k = 0; k < c_nsteps; k++) begin
            kk = k;
            exp_wr.push_back({4'd4, c_phase0 + kk * c_step});
            if (k == abort_k) break;
            if (dly_a[k] == 0) begin exp_to = 1; break; end
            m = mdl_mag(corr_a[k]);
            if (m > exp_mag) begin exp_mag = m; exp_phase = c_phase0 + kk * c_step; exp_idx = k; end
`ifdef ACQ_THRESH_EN
            if (m >= longint'(c_thresh)) break;
`endif
        end
        exp_done = (abort_k < 0);
    endtask

    // single compare process: bus writes, sync timing and results on done
    always @(negedge clk) begin
        if (reset) begin
            if (ss_strobe) begin
                strobe_cnt++;
                if (exp_wr.size() == 0) chk("unexpected_write", {ss_addr, ss_din}, 36'h0);
                else begin
                    chk("bus_write", {ss_addr, ss_din}, exp_wr.pop_front());
                    if (ss_addr == 4'd4) begin last_ph_cyc = cyc; last_ph_din = ss_din; ph_cnt++; end
                end
            end
            if (ss_sync || cyc == last_ph_cyc + 3) chk("sync_timing", ss_sync, cyc == last_ph_cyc + 3);
            if (ss_sync) last_sync_cyc = cyc;
            if (done) begin
                done_cnt++;
                chk("done_expected", 1'b1, exp_done);
                chk("done_best_mag", best_mag, exp_mag);
                chk("done_best_phase", best_phase, exp_phase);
                chk("done_best_idx", best_idx, exp_idx);
                chk("done_timeout_err", timeout_err, exp_to);
                chk("done_writes_left", exp_wr.size(), 0);
                if (exp_to) chk("timeout_len", cyc - last_sync_cyc, TO + 1);
                exp_done = 0;
            end
        end
    end

    task automatic respond(input int k);
        int last;
        if (spur_a[k] && dly_a[k] != 0) begin ss_push_corr = 1; ss_corr = $urandom; end
        if (xst_a[k]) begin
            start = 1; cfg_freq = $urandom; cfg_phase0 = $urandom; cfg_phase_step = $urandom;
            cfg_s1 = 4'($urandom); cfg_s2 = 4'($urandom); cfg_nsteps = 10'($urandom);
        end
        last = (dly_a[k] == 0) ? 1 : dly_a[k] + len_a[k];
        for (int j = 1; j <= last; j++) begin
            @(negedge clk);
            start = 0;
            if (dly_a[k] != 0 && j >= dly_a[k] && j < dly_a[k] + len_a[k]) begin
                ss_push_corr = 1;
                ss_corr = (j == dly_a[k]) ? corr_a[k] : $urandom;
            end else ss_push_corr = 0;
        end
    endtask

    task automatic run_search(input int abort_k);
        int k = 0, n = 0, d0 = done_cnt;
        build_model(abort_k);
        @(negedge clk);
        cfg_freq = c_freq; cfg_phase0 = c_phase0; cfg_phase_step = c_step; cfg_thresh = c_thresh;
        cfg_s1 = c_s1; cfg_s2 = c_s2; cfg_nsteps = 10'(c_nsteps); start = 1;
        @(negedge clk);
        start = 0;
        while (busy && n < 6000) begin
            if (ss_sync) begin
                if (k == abort_k) begin
                    @(negedge clk); abort = 1;
                    @(negedge clk); abort = 0;
                    chk("abort_busy", busy, 0);
                    chk("abort_strobe", ss_strobe, 0);
                    chk("abort_sync", ss_sync, 0);
                    chk("abort_best_mag", best_mag, exp_mag);
                    chk("abort_best_idx", best_idx, exp_idx);
                    chk("abort_writes_left", exp_wr.size(), 0);
                    break;
                end
                respond(k);
                k++;
            end else @(negedge clk);
            n++;
        end
        if (n >= 6000) chk("search_cycle_budget", n, 0);
        repeat (3) @(negedge clk);
        chk("done_count", done_cnt - d0, (abort_k < 0) ? 1 : 0);
        chk("idle_after", busy, 0);
    endtask

    task automatic default_steps();
        for (int i = 0; i < 16; i++) begin
            dly_a[i] = 1 + (i % 3); len_a[i] = 1; spur_a[i] = 0; xst_a[i] = 0; corr_a[i] = 0;
        end
        c_freq = 32'h1234_5678; c_s1 = 4'h3; c_s2 = 4'h9; c_thresh = 32'hFFFF_FFFF;
    endtask

    initial begin
        int s0;
        logic [31:0] r;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, timeout_err, ss_strobe, ss_sync, ss_addr, ss_din,
                              best_mag, best_phase, best_idx}, '0);
        reset = 1;
        @(negedge clk);

        default_steps();
        c_nsteps = 4; c_phase0 = 0; c_step = 32'h100;
        corr_a[0] = 10; corr_a[1] = -32'sd50; corr_a[2] = 50; corr_a[3] = 20;
        run_search(-1);
        chk("lit_best_idx", best_idx, 1);
        chk("lit_best_mag", best_mag, 50);
        chk("lit_best_phase", best_phase, 32'h100);

        default_steps();
        c_nsteps = 2; c_phase0 = 32'hFFFF_FF00; c_step = 32'h200; corr_a[0] = 3; corr_a[1] = 4;
        s0 = ph_cnt;
        run_search(-1);
        chk("lit_wrap_phase_din", last_ph_din, 32'h0000_0100);
        chk("lit_phase_writes", ph_cnt - s0, 2);

        default_steps();
        c_nsteps = 3; c_phase0 = 5; c_step = 7; dly_a[0] = 0;
        run_search(-1);
        chk("lit_timeout_err", timeout_err, 1);
        chk("lit_timeout_mag", best_mag, 0);
        repeat (5) @(negedge clk);
        chk("lit_timeout_sticky", timeout_err, 1);

        default_steps();
        c_nsteps = 5; c_phase0 = 0; c_step = 1; corr_a[0] = 3; corr_a[1] = 9; corr_a[2] = 100;
        run_search(2);
        chk("lit_abort_best_mag", best_mag, 9);
        chk("lit_timeout_cleared", timeout_err, 0);
        @(negedge clk); start = 1; abort = 1;
        @(negedge clk); start = 0; abort = 0;
        chk("lit_abort_beats_start", busy, 0);

        default_steps();
        c_nsteps = 1; c_phase0 = 0; c_step = 0; corr_a[0] = 32'h8000_0000;
        run_search(-1);
        chk("lit_sat_mag", best_mag, 32'h7FFF_FFFF);

        default_steps();
        c_nsteps = 0; c_phase0 = 1; c_step = 1;
        s0 = strobe_cnt;
        run_search(-1);
        chk("lit_nsteps0_strobes", strobe_cnt - s0, 0);
        chk("lit_nsteps0_mag", best_mag, 0);

        default_steps();
        c_nsteps = 3; c_phase0 = 0; c_step = 32'h10; c_thresh = 40;
        corr_a[0] = 10; corr_a[1] = 45; corr_a[2] = 90;
        run_search(-1);
`ifdef ACQ_THRESH_EN
        chk("lit_thresh_mag", best_mag, 45);
        chk("lit_thresh_idx", best_idx, 1);
`else
        chk("lit_nothresh_mag", best_mag, 90);
        chk("lit_nothresh_idx", best_idx, 2);
`endif

        for (int t = 0; t < 40; t++) begin
            c_freq = $urandom; c_phase0 = $urandom; c_step = $urandom;
            c_s1 = 4'($urandom); c_s2 = 4'($urandom); c_thresh = $urandom_range(0, 3000);
            c_nsteps = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
            for (int i = 0; i < 16; i++) begin
                r = $urandom;
                case ($urandom_range(0, 3))
                    0: corr_a[i] = $urandom_range(0, 4000);
                    1: corr_a[i] = -$urandom_range(0, 4000);
                    2: corr_a[i] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : r;
                    default: corr_a[i] = ($urandom_range(0, 1) == 0) ? 32'd777 : -32'sd777;
                endcase
                dly_a[i] = $urandom_range(1, 6);
                len_a[i] = $urandom_range(1, 3);
                spur_a[i] = $urandom_range(0, 2) == 0;
                xst_a[i] = $urandom_range(0, 3) == 0;
            end
            run_search(($urandom_range(0, 9) == 0 && c_nsteps > 0) ? $urandom_range(0, c_nsteps - 1) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ss_acq_ctrl.md
SS_ACQ_CTRL -- requirements
Module: ss_acq_ctrl

Interface
REQ-001 SHALL have parameter NSTEP_W, default 10, width of step count/index.
REQ-002 SHALL have parameter TIMEOUT, default 4096, maximum cycles to wait for push_corr per step.
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle search request, sampled in IDLE only.
REQ-006 SHALL have port abort  in  1  terminate search, return to IDLE.
REQ-007 SHALL have ports cfg_freq, cfg_phase0, cfg_phase_step, cfg_thresh  in  32 each  NCO word, first phase, phase increment, early-stop threshold; sampled on accepted start.
REQ-008 SHALL have ports cfg_s1, cfg_s2  in  4 each  Gold-code tap selects; cfg_nsteps  in  NSTEP_W  number of phase hypotheses.
REQ-009 SHALL have ports busy  out  1; done  out  1  one-cycle pulse; timeout_err  out  1  sticky until next start.
REQ-010 SHALL have ports best_phase  out  32; best_mag  out  32 unsigned; best_idx  out  NSTEP_W.
REQ-011 SHALL have correlator-side ports ss_din  out  32; ss_addr  out  4; ss_strobe  out  1; ss_sync  out  1; ss_push_corr  in  1; ss_corr  in  32 signed.

Function
REQ-012 SHALL implement states IDLE, WR_FREQ, WR_S1, WR_S2, WR_PHASE, SETTLE, SYNC, WAIT, EVAL, DONE.
REQ-013 SHALL, on start in IDLE with cfg_nsteps!=0, latch all cfg_* inputs, clear best_*/timeout_err, set k=0, enter WR_FREQ; with cfg_nsteps==0 SHALL go to DONE with no bus traffic and best_* = 0.
REQ-014 SHALL drive one strobe cycle per write state: WR_FREQ addr 0 din freq; WR_S1 addr 8 din {28'b0,s1}; WR_S2 addr 12 din {28'b0,s2}; WR_PHASE addr 4 din phase_k.
REQ-015 SHALL visit WR_FREQ/WR_S1/WR_S2 only for k=0; steps k>0 SHALL go EVAL -> WR_PHASE directly.
REQ-016 SHALL compute phase_k = cfg_phase0 + k*cfg_phase_step modulo 2^32 by running addition (wrap silently).
REQ-017 SHALL hold SETTLE exactly 2 cycles, then assert ss_sync for exactly 1 cycle in SYNC, then enter WAIT.
REQ-018 SHALL, in WAIT, capture ss_corr on the first cycle ss_push_corr==1; ss_push_corr outside WAIT SHALL be ignored; later cycles of a multi-cycle push SHALL be ignored.
REQ-019 SHALL compute mag = |ss_corr|, saturating -2^31 to 32'h7FFF_FFFF.
REQ-020 SHALL, in EVAL, update best_* when mag > best_mag strictly (ties keep earliest k); then k+1==cfg_nsteps -> DONE, else k++ and WR_PHASE.
REQ-021 SHALL, if WAIT lasts TIMEOUT cycles without push, set timeout_err and go DONE keeping best_* from completed steps.
REQ-022 SHALL pulse done for one cycle in DONE, then return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-023 SHALL, on abort in any non-IDLE state, go to IDLE next cycle, deassert ss_strobe/ss_sync, not pulse done, retain best_*; abort and start together in IDLE: abort wins.
REQ-024 SHALL ignore start while busy.
REQ-025 SHALL drive ss_strobe, ss_sync registered; ss_addr/ss_din hold last value when strobe low.

Reset
REQ-026 SHALL, when reset==0 at clk edge, enter IDLE and zero busy, done, timeout_err, best_*, ss_din, ss_addr, ss_strobe, ss_sync, k, timeout counter.

Configuration
REQ-027 SHALL compile early-stop logic only when ACQ_THRESH_EN is defined: after EVAL, mag >= cfg_thresh ends search (DONE) regardless of remaining steps.
REQ-028 SHALL, without ACQ_THRESH_EN, ignore cfg_thresh and always run cfg_nsteps steps.

Structure
REQ-029 SHALL place state enum, register address constants (FREQ=0, PHASE=4, S1=8, S2=12) and mag width in shared package ss_pkg.
REQ-030 SHALL isolate magnitude + compare/update of best_* in sub-module ss_peak_track.

Verification
REQ-031 Bench: start, nsteps=4, phase0=0, step=0x100, model corr 10,-50,50,20 -> best_idx=1, best_mag=50, best_phase=0x100, one done.
REQ-032 Bench: phase0=0xFFFF_FF00, step=0x200, nsteps=2 -> second WR_PHASE din=0x0000_0100.
REQ-033 Bench: model never pushes -> timeout_err=1 after 4096 WAIT cycles, done pulses, best_mag=0.
REQ-034 Bench: abort during WAIT of k=2 -> IDLE next cycle, no done, ss_sync/ss_strobe low.
REQ-035 Bench: corr=-2^31 -> best_mag=0x7FFF_FFFF; nsteps=0 -> done without strobe.
REQ-036 Bench (ACQ_THRESH_EN): thresh=40, corr 10,45,90 -> stop after k=1, best_mag=45.
